// File: rtl/fetch_pkg.sv
// Shared types, widths and helpers for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned INSTN_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSTN_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_SLOT = 2'd1,
    DROP      = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   instn;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  // Sequential PC step; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(INSTN_BYTES);
  endfunction

  // Force an address onto a word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(INSTN_BYTES - 1);
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instruction, pc} holding register used when fetch data
// arrives while IF/ID is stalled.
module if_skid_buf
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [XLEN-1:0]   instn_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              full,
  output logic [XLEN-1:0]   instn_out,
  output logic [ADDR_W-1:0] pc_out
);

  fetch_entry_t entry_q, entry_d;
  logic         full_q, full_d;

  // Load takes priority over clear if both are ever raised together.
  always_comb begin
    entry_d = entry_q;
    full_d  = full_q;
    if (clear) begin
      full_d = 1'b0;
    end
    if (load) begin
      entry_d.instn = instn_in;
      entry_d.pc    = pc_in;
      full_d        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
      full_q  <= 1'b0;
    end else begin
      entry_q <= entry_d;
      full_q  <= full_d;
    end
  end

  assign full      = full_q;
  assign instn_out = entry_q.instn;
  assign pc_out    = entry_q.pc;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ready
// handshake and presents {instruction, pc, pc+4} to the IF/ID register.
module if_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0]   NOP_INSTN = NOP_INSTN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   inst_out,
  output logic [ADDR_W-1:0] currpc,
  output logic [ADDR_W-1:0] nextpc,
  output logic              inst_valid
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0] currpc_q, currpc_d;
  logic [ADDR_W-1:0] nextpc_q, nextpc_d;
  logic              valid_q, valid_d;

  logic              skid_load;
  logic              skid_clear;
  logic              skid_full;
  logic [XLEN-1:0]   skid_instn;
  logic [ADDR_W-1:0] skid_pc;

  logic              can_accept;
  logic              out_fire;
  logic [ADDR_W-1:0] redir_pc;

  assign can_accept = ~valid_q | ~stall;
  assign out_fire   = valid_q & ~stall;
  assign redir_pc   = word_align(redirect_pc);

  // The request stays up (address stable) in RUN and DROP until ready.
  assign imem_req  = ~reset & (state_q != WAIT_SLOT);
  assign imem_addr = pc_q;

  if_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .instn_in  (imem_rdata),
    .pc_in     (pc_q),
    .full      (skid_full),
    .instn_out (skid_instn),
    .pc_out    (skid_pc)
  );

  // Next-state, PC and output-register update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    inst_d     = inst_q;
    currpc_d   = currpc_q;
    nextpc_d   = nextpc_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    unique case (state_q)
      RUN: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_d    = redir_pc;
            valid_d = 1'b0;
          end else if (can_accept) begin
            inst_d   = imem_rdata;
            currpc_d = pc_q;
            nextpc_d = pc_inc(pc_q);
            valid_d  = 1'b1;
            pc_d     = pc_inc(pc_q);
          end else begin
            skid_load = 1'b1;
            pc_d      = pc_inc(pc_q);
            state_d   = WAIT_SLOT;
          end
        end else if (redirect) begin
          pend_pc_d = redir_pc;
          valid_d   = 1'b0;
          state_d   = DROP;
        end else if (out_fire) begin
          valid_d = 1'b0;
        end
      end

      WAIT_SLOT: begin
        if (redirect) begin
          skid_clear = 1'b1;
          valid_d    = 1'b0;
          pc_d       = redir_pc;
          state_d    = RUN;
        end else if (!stall) begin
          inst_d     = skid_instn;
          currpc_d   = skid_pc;
          nextpc_d   = pc_inc(skid_pc);
          valid_d    = 1'b1;
          skid_clear = 1'b1;
          state_d    = RUN;
        end
      end

      DROP: begin
        // The in-flight word belongs to the flushed path; the newest target wins.
        valid_d = 1'b0;
        if (imem_ready) begin
          pc_d    = redirect ? redir_pc : pend_pc_q;
          state_d = RUN;
        end else if (redirect) begin
          pend_pc_d = redir_pc;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    if (!valid_d) begin
      inst_d = NOP_INSTN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      inst_q    <= NOP_INSTN;
      currpc_q  <= RESET_PC;
      nextpc_q  <= pc_inc(RESET_PC);
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      inst_q    <= inst_d;
      currpc_q  <= currpc_d;
      nextpc_q  <= nextpc_d;
      valid_q   <= valid_d;
    end
  end

  assign inst_out   = inst_q;
  assign currpc     = currpc_q;
  assign nextpc     = nextpc_q;
  assign inst_valid = valid_q;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the program counter and issues word requests to instruction memory over a request/ready handshake with variable latency. Presents {instruction, current PC, PC+4} with a valid flag to IF/ID, honouring hazard stalls and branch/jump redirects. A one-entry skid buffer absorbs data that returns while the stage is stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTN, 32'h0000_0000, instruction word driven on inst_out when no valid instruction is held

Ports:
clk  input  1  single clock; all state updates on posedge clk
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit: IF/ID does not accept this cycle
redirect  input  1  taken branch/jump from a later stage; flushes fetch
redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address (byte address, [1:0]=0)
imem_ready  input  1  memory returns imem_rdata for the pending request this cycle
imem_rdata  input  32  fetched instruction word
inst_out  output  32  instruction to IF/ID
currpc  output  32  PC of inst_out
nextpc  output  32  currpc+4, to IF/ID
inst_valid  output  1  inst_out/currpc/nextpc hold a live instruction

Behaviour:
- Reset (reset=1 at posedge): pc=RESET_PC, state=RUN, inst_valid=0, inst_out=NOP_INSTN, currpc=RESET_PC, nextpc=RESET_PC+4, skid empty, pend_pc=0. imem_req forced 0 while reset is high. Any outstanding memory request is abandoned; the memory model must tolerate this.
- Consumption: IF/ID takes the outputs at an edge where inst_valid=1 and stall=0. can_accept = ~inst_valid | ~stall.
- Handshake: once imem_req=1, imem_addr stays stable and imem_req stays high until imem_ready=1 (data valid the same cycle). Back-to-back requests are allowed; the next request may start the cycle after ready.
- State RUN: imem_req=1, imem_addr=pc.
  - ready & ~redirect & can_accept: inst_out<=rdata, currpc<=pc, nextpc<=pc+4, inst_valid<=1, pc<=pc+4. One-cycle latency from ready to outputs.
  - ready & ~redirect & ~can_accept: skid<={rdata,pc}, pc<=pc+4, go to WAIT_SLOT. Outputs hold.
  - ready & redirect: drop rdata, pc<=redirect_pc, inst_valid<=0, stay in RUN.
  - ~ready & redirect: pend_pc<=redirect_pc, inst_valid<=0, go to DROP.
  - ~ready & ~redirect: if out_fire (inst_valid & ~stall), inst_valid<=0; otherwise hold.
- State WAIT_SLOT: imem_req=0.
  - redirect: clear skid, inst_valid<=0, pc<=redirect_pc, go to RUN.
  - else if ~stall: load outputs from skid (nextpc = skid_pc+4), inst_valid<=1, clear skid, go to RUN.
  - else hold.
- State DROP: imem_req=1 at the old address until ready.
  - ready: discard rdata, pc<=pend_pc, or redirect_pc if redirect is also high this cycle; go to RUN.
  - redirect without ready: pend_pc<=redirect_pc (latest redirect wins).
  - inst_valid stays 0.
- Priority: reset > redirect > stall > normal advance.
- Arithmetic: pc+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 0; nextpc for that PC is 0.
- Outputs are held unchanged while stall=1 and inst_valid=1 (the skid buffer absorbs any late ready).
- No instruction is ever duplicated or lost except on a redirect flush.

Decomposition:
- Shared package fetch_pkg:
  - state enum {RUN, WAIT_SLOT, DROP}
  - NOP_INSTN default
  - INSTN_BYTES = 4
  - 32-bit word/address widths
- One sub-module, if_skid_buf: 1-entry {instn, pc} buffer with load/clear/full and synchronous active-high reset. The FSM and PC stay in if_fetch_stage.

Test Plan:
- Reset with RESET_PC=0, memory with zero wait states, stall=0 -> first valid at cycle 2: inst_out=mem[0], currpc=0, nextpc=4. Then one instruction per cycle: currpc 4, 8, 12.
- Memory with 3 wait states -> imem_addr stays at 0x8 for 4 cycles. inst_valid pulses once per 4 cycles with the correct PC, and no duplicates.
- Stall held 3 cycles while a ready returns for pc=0x10 -> outputs hold currpc=0x0C, skid captures 0x10, imem_req=0. On stall release, currpc=0x10 with no gap or loss.
- Redirect to 0x40 in the same cycle as ready -> fetched data dropped, inst_valid=0 next cycle, next imem_addr=0x40, then currpc=0x40.
- Redirect to 0x80 during a 2-wait-state fetch, then redirect to 0x90 before ready -> old data discarded and the next request goes to 0x90. Also: PC at 0xFFFFFFFC -> nextpc=0, following fetch address 0.
- Reset asserted mid-WAIT_SLOT with stall=1 -> next cycle inst_valid=0, inst_out=NOP_INSTN, imem_addr=RESET_PC, skid empty.
